vc_latency_pipe_ctrl: RTL

VC_LATENCY_PIPE_CTRL -- requirements
Module: vc_latency_pipe_ctrl

---
 rtl/vc_latency_pipe_pkg.sv | 14 +
 rtl/vc_latency_pipe_queue.sv | 65 ++++++
 rtl/vc_latency_pipe_ctrl.sv | 82 ++++++++
 3 files changed

// File: rtl/vc_latency_pipe_pkg.sv
// Shared width helpers for the latency-pipe controller and its output queue.
package vc_latency_pipe_pkg;

    // Bits needed to hold a count from 0 to n inclusive.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    // Bits needed to index n entries (at least one bit so a 1-entry queue still has a pointer).
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vc_latency_pipe_queue.sv
// Circular output queue: storage, head/tail pointers and occupancy count.
module vc_latency_pipe_queue
    import vc_latency_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int DEPTH      = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic                      rd_en,
    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic [cnt_w(DEPTH)-1:0]   occupancy,
    output logic                      empty
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    logic [CW-1:0]         count;
    logic                  full;

    // Advance a pointer, wrapping at the last entry.
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (32'(p) == 32'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Storage write at the tail.
    // NOTE: data storage has no reset; occupancy and pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem[tail] <= wr_data;
    end

    // Pointer and occupancy bookkeeping; simultaneous write and read leaves count unchanged.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (wr_en) tail <= wrap_inc(tail);
            if (rd_en) head <= wrap_inc(head);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign rd_data   = mem[head];
    assign empty     = (count == '0);
    assign full      = (32'(count) == 32'(DEPTH));
    assign occupancy = count;

    // The credit scheme upstream must never let a write land on a full queue.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(wr_en && full && !rd_en));
    a_no_underflow: assert property (@(posedge clk) disable iff (reset) !(rd_en && empty));

endmodule

// File: rtl/vc_latency_pipe_ctrl.sv
// Credit-based controller around a fixed-latency external delay line feeding an output queue.
module vc_latency_pipe_ctrl
    import vc_latency_pipe_pkg::*;
#(
    parameter int DATA_WIDTH  = 12,
    parameter int NUM_CYCLES  = 4,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_val,
    output logic                          in_rdy,
    input  logic [DATA_WIDTH-1:0]         in_msg,
    output logic [DATA_WIDTH-1:0]         pipe_d,
    input  logic [DATA_WIDTH-1:0]         pipe_q,
    output logic                          out_val,
    input  logic                          out_rdy,
    output logic [DATA_WIDTH-1:0]         out_msg,
    output logic [cnt_w(NUM_CYCLES)-1:0]  inflight,
    output logic [cnt_w(QUEUE_DEPTH)-1:0] occupancy
);

    localparam int IW = cnt_w(NUM_CYCLES);
    localparam int QW = cnt_w(QUEUE_DEPTH);

    logic [NUM_CYCLES-1:0] vld_sr;
    logic [IW-1:0]         inflight_q;
    logic [QW-1:0]         q_occ;
    logic                  q_empty;
    logic                  in_xfer;
    logic                  pipe_exit;
    logic                  out_xfer;

    // A slot is free only when delay-line messages plus queued messages leave a credit;
    // counts are registered, so a same-cycle dequeue does not free a credit until next cycle.
    assign in_rdy    = !reset && ((32'(inflight_q) + 32'(q_occ)) < 32'(QUEUE_DEPTH));
    assign in_xfer   = in_val && in_rdy;
    assign pipe_d    = in_msg;
    assign pipe_exit = vld_sr[NUM_CYCLES-1];
    assign out_val   = !reset && !q_empty;
    assign out_xfer  = out_val && out_rdy;
    assign inflight  = reset ? '0 : inflight_q;
    assign occupancy = reset ? '0 : q_occ;

    // Valid bits shadow the delay line; the last bit says pipe_q holds a live message.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_sr <= '0;
        end else begin
            vld_sr[0] <= in_xfer;
            for (int i = 1; i < NUM_CYCLES; i++) vld_sr[i] <= vld_sr[i-1];
        end
    end

    // Count messages currently inside the delay line.
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_q <= '0;
        end else begin
            case ({in_xfer, pipe_exit})
                2'b10:   inflight_q <= inflight_q + IW'(1);
                2'b01:   inflight_q <= inflight_q - IW'(1);
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    vc_latency_pipe_queue #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (QUEUE_DEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (pipe_exit),
        .wr_data   (pipe_q),
        .rd_en     (out_xfer),
        .rd_data   (out_msg),
        .occupancy (q_occ),
        .empty     (q_empty)
    );

endmodule
